// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and constants for the CPU request dispatcher
//
// Contents:
//   cpu_opcode_e  : CPU-side opcodes (encrypt, decrypt, hash, reserved)
//   req_opcode_e  : internal request-bus opcodes (KEY_RD, TEXT_RD, TEXT_WR)
//   MEM_ID/CTRL_ID: fixed bus IDs for the memory unit and this controller
//   cpu_req_t     : one buffered CPU request
//   safe_clog2    : pointer width helper that never returns 0
package ctrl_pkg;

  localparam int CTRL_ADDR_W       = 10;
  localparam int CTRL_CPU_WENC_W   = 3;
  localparam int CTRL_CPU_OPCODE_W = 2;

  localparam logic [3:0] MEM_ID  = 4'd0;
  localparam logic [3:0] CTRL_ID = 4'd1;

  typedef enum logic [CTRL_CPU_OPCODE_W-1:0] {
    CPU_ENCRYPT = 2'd0,
    CPU_DECRYPT = 2'd1,
    CPU_HASH    = 2'd2,
    CPU_RSVD    = 2'd3
  } cpu_opcode_e;

  typedef enum logic [1:0] {
    OP_KEY_RD  = 2'd0,
    OP_TEXT_RD = 2'd1,
    OP_TEXT_WR = 2'd2
  } req_opcode_e;

  typedef struct packed {
    logic [CTRL_ADDR_W-1:0]     text_addr;
    logic [CTRL_CPU_WENC_W-1:0] text_width;
    logic [CTRL_ADDR_W-1:0]     key_addr;
    cpu_opcode_e                opcode;
  } cpu_req_t;

  // A depth of 1 or 2 still needs a 1-bit pointer.
  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpu_req_fifo.sv
// rtl/cpu_req_fifo.sv - small synchronous FIFO buffering CPU requests
//
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   push, push_data   : write strobe and entry
//   pop, pop_data     : read strobe and head entry (valid while !empty)
//   full, empty       : occupancy flags
module cpu_req_fifo
  import ctrl_pkg::*;
#(
  parameter type T     = cpu_req_t,
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int PTR_W = safe_clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  // Storage carries no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cpu_req_dispatcher.sv
// rtl/cpu_req_dispatcher.sv - expands buffered CPU requests into internal bus requests
//
// Optional feature macro: DISPATCH_PERF_CNT_EN (adds perf_seq_cnt / perf_stall_cnt)
//
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   cpu_text_addr/width        : text buffer address and width encoding
//   cpu_key_addr, cpu_opcode   : key address, 0=enc 1=dec 2=hash 3=reserved
//   cpu_valid / cpu_ready      : CPU handshake, ready = request FIFO not full
//   req_addr/width/dest        : internal request payload (registered)
//   req_source_id, req_opcode  : this block's ID, 0=KEY_RD 1=TEXT_RD 2=TEXT_WR
//   req_valid / req_ready      : internal handshake
//   req_done                   : pulse after the final TEXT_WR of a sequence
//   err_opcode                 : pulse when a reserved opcode is discarded
//   busy                       : sequence in flight or requests buffered
//   perf_seq_cnt/stall_cnt     : saturating counters (DISPATCH_PERF_CNT_EN only)
module cpu_req_dispatcher
  import ctrl_pkg::*;
#(
  parameter int ADDR_W                = 10,
  parameter int CPU_ADDR_W_ENCODING_W = 3,
  parameter int ADDR_W_ENCODING_W     = 4,
  parameter int CPU_OPCODE_W          = 2,
  parameter int OPCODE_W              = 2,
  parameter int SRC_ID_W              = 4,
  parameter int FIFO_DEPTH            = 2,
  parameter logic [ADDR_W_ENCODING_W-1:0] KEY_WIDTH_ENC = 4'd7,
  parameter logic [SRC_ID_W-1:0]          MEM_ID        = ctrl_pkg::MEM_ID,
  parameter logic [SRC_ID_W-1:0]          CTRL_ID       = ctrl_pkg::CTRL_ID
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            cpu_text_addr,
  input  logic [CPU_ADDR_W_ENCODING_W-1:0] cpu_text_width,
  input  logic [ADDR_W-1:0]            cpu_key_addr,
  input  logic [CPU_OPCODE_W-1:0]      cpu_opcode,
  input  logic                         cpu_valid,
  output logic                         cpu_ready,
  output logic [ADDR_W-1:0]            req_addr,
  output logic [ADDR_W_ENCODING_W-1:0] req_width,
  output logic [SRC_ID_W-1:0]          req_dest,
  output logic [SRC_ID_W-1:0]          req_source_id,
  output logic [OPCODE_W-1:0]          req_opcode,
  output logic                         req_valid,
  input  logic                         req_ready,
  output logic                         req_done,
  output logic                         err_opcode,
  output logic                         busy
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [15:0]                  perf_seq_cnt,
  output logic [15:0]                  perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_TEXT = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  state_e   state_q, state_d;
  cpu_req_t work_q, work_d;
  cpu_req_t push_data;
  cpu_req_t head;
  logic     fifo_full, fifo_empty;
  logic     push, pop;

  logic                         valid_d;
  logic [ADDR_W-1:0]            addr_d;
  logic [ADDR_W_ENCODING_W-1:0] width_d;
  logic [SRC_ID_W-1:0]          dest_d;
  logic [SRC_ID_W-1:0]          src_d;
  logic [OPCODE_W-1:0]          opcode_d;
  logic                         done_d;
  logic                         err_d;

  assign cpu_ready = !fifo_full;
  assign push      = cpu_valid && cpu_ready;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

  assign push_data = '{
    text_addr:  cpu_text_addr,
    text_width: cpu_text_width,
    key_addr:   cpu_key_addr,
    opcode:     cpu_opcode_e'(cpu_opcode)
  };

  cpu_req_fifo #(
    .T     (cpu_req_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop    = 1'b1;
          work_d = head;
          unique case (head.opcode)
            CPU_RSVD: err_d   = 1'b1;
            CPU_HASH: state_d = ST_TEXT;
            default:  state_d = ST_KEY;
          endcase
        end
      end
      ST_KEY:  if (req_ready) state_d = ST_TEXT;
      ST_TEXT: if (req_ready) state_d = ST_WB;
      ST_WB: begin
        if (req_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are a function of the upcoming state and working request, so
    // a stalled request re-registers identical values and holds stable.
    valid_d  = 1'b0;
    addr_d   = '0;
    width_d  = '0;
    dest_d   = '0;
    src_d    = '0;
    opcode_d = '0;
    unique case (state_d)
      ST_KEY: begin
        valid_d  = 1'b1;
        addr_d   = ADDR_W'(work_d.key_addr);
        width_d  = KEY_WIDTH_ENC;
        dest_d   = MEM_ID;
        src_d    = CTRL_ID;
        opcode_d = OPCODE_W'(OP_KEY_RD);
      end
      ST_TEXT, ST_WB: begin
        valid_d  = 1'b1;
        addr_d   = ADDR_W'(work_d.text_addr);
        width_d  = ADDR_W_ENCODING_W'(work_d.text_width);
        dest_d   = MEM_ID;
        src_d    = CTRL_ID;
        opcode_d = (state_d == ST_WB) ? OPCODE_W'(OP_TEXT_WR) : OPCODE_W'(OP_TEXT_RD);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      work_q        <= '0;
      req_valid     <= 1'b0;
      req_addr      <= '0;
      req_width     <= '0;
      req_dest      <= '0;
      req_source_id <= '0;
      req_opcode    <= '0;
      req_done      <= 1'b0;
      err_opcode    <= 1'b0;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      req_valid     <= valid_d;
      req_addr      <= addr_d;
      req_width     <= width_d;
      req_dest      <= dest_d;
      req_source_id <= src_d;
      req_opcode    <= opcode_d;
      req_done      <= done_d;
      err_opcode    <= err_d;
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_seq_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (req_done && perf_seq_cnt != 16'hFFFF)
        perf_seq_cnt <= perf_seq_cnt + 16'd1;
      if (req_valid && !req_ready && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
